// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the hazard unit.
// Optional statistics counters are enabled with HAZARD_STATS_EN.
package hazard_unit_pkg;

   localparam int AW = 4;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [AW-1:0] PC_REG = 4'd15;

   typedef struct packed {
      logic [AW-1:0] wa3;
      logic          regwrite;
      logic          memtoreg;
      logic          pcsrc;
   } stage_t;

   localparam stage_t BUBBLE = '0;

   // M beats W; R15 reads never forward.
   function automatic logic [1:0] fwd_sel(
      input logic [AW-1:0] ra,
      input stage_t        m,
      input stage_t        w
   );
      if (ra == PC_REG)
         return FWD_RF;
      else if (m.regwrite && m.wa3 == ra)
         return FWD_MEM;
      else if (w.regwrite && w.wa3 == ra)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode/Execute hazard signals between datapath and hazard unit.
// Statistics counters exist only with HAZARD_STATS_EN.
interface hazard_unit_if #(
   parameter int REG_AW = 4
`ifdef HAZARD_STATS_EN
   , parameter int CNT_W = 16
`endif
);

   logic [REG_AW-1:0] RA1D;
   logic [REG_AW-1:0] RA2D;
   logic [REG_AW-1:0] WA3D;
   logic              RegWriteD;
   logic              MemtoRegD;
   logic              PCSrcD;
   logic              CondExE;
   logic              BranchTakenE;
   logic [1:0]        ForwardAE;
   logic [1:0]        ForwardBE;
   logic              StallF;
   logic              StallD;
   logic              FlushD;
   logic              FlushE;
`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0]  StallCnt;
   logic [CNT_W-1:0]  FlushCnt;
   logic [CNT_W-1:0]  FwdCnt;
`endif

   modport master (
      output RA1D, RA2D, WA3D,
      output RegWriteD, MemtoRegD, PCSrcD,
      output CondExE, BranchTakenE,
      input  ForwardAE, ForwardBE,
      input  StallF, StallD, FlushD, FlushE
`ifdef HAZARD_STATS_EN
      , input StallCnt, FlushCnt, FwdCnt
`endif
   );

   modport slave (
      input  RA1D, RA2D, WA3D,
      input  RegWriteD, MemtoRegD, PCSrcD,
      input  CondExE, BranchTakenE,
      output ForwardAE, ForwardBE,
      output StallF, StallD, FlushD, FlushE
`ifdef HAZARD_STATS_EN
      , output StallCnt, FlushCnt, FwdCnt
`endif
   );

endinterface

// File: rtl/hazard_unit_track.sv
// E/M/W shadow chain of destination-register info.
// Flush inserts a bubble in E; CondExE gates writes leaving E.
module hazard_track
   import hazard_unit_pkg::*;
#(
   parameter int REG_AW = AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] i_ra1d,
   input  logic [REG_AW-1:0] i_ra2d,
   input  stage_t            i_d,
   input  logic              i_flush_e,
   input  logic              i_cond_e,
   output logic [REG_AW-1:0] o_ra1e,
   output logic [REG_AW-1:0] o_ra2e,
   output stage_t            o_e,
   output stage_t            o_m,
   output stage_t            o_w
);

   logic [REG_AW-1:0] r_ra1e;
   logic [REG_AW-1:0] r_ra2e;
   stage_t            r_e;
   stage_t            r_m;
   stage_t            r_w;
   stage_t            w_m_nxt;

   always_comb begin
      w_m_nxt          = r_e;
      w_m_nxt.regwrite = r_e.regwrite & i_cond_e;
      w_m_nxt.pcsrc    = r_e.pcsrc & i_cond_e;
      w_m_nxt.memtoreg = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ra1e <= '0;
         r_ra2e <= '0;
         r_e    <= BUBBLE;
         r_m    <= BUBBLE;
         r_w    <= BUBBLE;
      end else begin
         if (i_flush_e) begin
            r_ra1e <= '0;
            r_ra2e <= '0;
            r_e    <= BUBBLE;
         end else begin
            r_ra1e <= i_ra1d;
            r_ra2e <= i_ra2d;
            r_e    <= i_d;
         end
         r_m <= w_m_nxt;
         r_w <= r_m;
      end
   end

   assign o_ra1e = r_ra1e;
   assign o_ra2e = r_ra2e;
   assign o_e    = r_e;
   assign o_m    = r_m;
   assign o_w    = r_w;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward resolver for the 5-stage pipeline.
// HAZARD_STATS_EN adds saturating stall/flush/forward counters.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int REG_AW = AW
`ifdef HAZARD_STATS_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic         clk,
   input  logic         reset,
   hazard_unit_if.slave hz
);

   stage_t            w_d;
   stage_t            w_e;
   stage_t            w_m;
   stage_t            w_w;
   logic [REG_AW-1:0] w_ra1e;
   logic [REG_AW-1:0] w_ra2e;
   logic [1:0]        w_fwd_a;
   logic [1:0]        w_fwd_b;
   logic              w_ldr_stall;
   logic              w_pc_pend;
   logic              w_stall_d;
   logic              w_flush_d;
   logic              w_flush_e;
   logic              w_unused;

   assign w_d = '{
      wa3:      hz.WA3D,
      regwrite: hz.RegWriteD,
      memtoreg: hz.MemtoRegD,
      pcsrc:    hz.PCSrcD
   };

   hazard_track #(
      .REG_AW (REG_AW)
   ) u_track (
      .clk       (clk),
      .reset     (reset),
      .i_ra1d    (hz.RA1D),
      .i_ra2d    (hz.RA2D),
      .i_d       (w_d),
      .i_flush_e (w_flush_e),
      .i_cond_e  (hz.CondExE),
      .o_ra1e    (w_ra1e),
      .o_ra2e    (w_ra2e),
      .o_e       (w_e),
      .o_m       (w_m),
      .o_w       (w_w)
   );

   assign w_unused = ^{w_m.memtoreg, w_w.memtoreg};

   assign w_fwd_a = fwd_sel(w_ra1e, w_m, w_w);
   assign w_fwd_b = fwd_sel(w_ra2e, w_m, w_w);

   assign w_ldr_stall = w_e.memtoreg & w_e.regwrite &
                        ((w_e.wa3 == hz.RA1D) |
                         (w_e.wa3 == hz.RA2D));

   assign w_pc_pend = hz.PCSrcD | w_e.pcsrc | w_m.pcsrc;

   assign w_stall_d = w_ldr_stall;
   assign w_flush_d = w_pc_pend | w_w.pcsrc | hz.BranchTakenE;
   assign w_flush_e = w_ldr_stall | hz.BranchTakenE;

   assign hz.ForwardAE = w_fwd_a;
   assign hz.ForwardBE = w_fwd_b;
   assign hz.StallF    = w_ldr_stall | w_pc_pend;
   assign hz.StallD    = w_stall_d;
   assign hz.FlushD    = w_flush_d;
   assign hz.FlushE    = w_flush_e;

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic [CNT_W-1:0] r_fwd_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         if (w_stall_d && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if ((w_flush_d | w_flush_e) && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         if ((w_fwd_a != FWD_RF || w_fwd_b != FWD_RF) &&
             r_fwd_cnt != '1)
            r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
      end
   end

   assign hz.StallCnt = r_stall_cnt;
   assign hz.FlushCnt = r_flush_cnt;
   assign hz.FwdCnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus
// randomized traffic against an instruction-level reference model.
module tb_hazard_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_unit_if #(
      .REG_AW (4)
`ifdef HAZARD_STATS_EN
      , .CNT_W (16)
`endif
   ) hz ();

   hazard_unit dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int ra1, ra2, wa3;
      bit rw, ld, pc;
   } ins_t;

   // instruction currently in E, M, W (as the architecture sees them)
   ins_t in_e, in_m, in_w;
   ins_t cur_d;
   bit   cur_cond;
   int   e_fa, e_fb;
   bit   e_sf, e_sd, e_fd, e_fe;
   int   c_stall, c_flush, c_fwd;

   function automatic ins_t nop_ins();
      ins_t n;
      n = '{ra1: 0, ra2: 0, wa3: 0, rw: 0, ld: 0, pc: 0};
      return n;
   endfunction

   function automatic int fwd_of(int ra);
      if (ra == 15) return 0;
      if (in_m.rw && in_m.wa3 == ra) return 2;
      if (in_w.rw && in_w.wa3 == ra) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      in_e = nop_ins(); in_m = nop_ins(); in_w = nop_ins();
      c_stall = 0; c_flush = 0; c_fwd = 0;
   endtask

   task automatic drive(input int ra1, ra2, wa3,
                        input bit rw, ld, pc, cond, br);
      bit ldr, pcp;
      @(negedge clk);
      hz.RA1D = ra1[3:0]; hz.RA2D = ra2[3:0]; hz.WA3D = wa3[3:0];
      hz.RegWriteD = rw; hz.MemtoRegD = ld; hz.PCSrcD = pc;
      hz.CondExE = cond; hz.BranchTakenE = br;
      cur_d = '{ra1: ra1, ra2: ra2, wa3: wa3, rw: rw, ld: ld, pc: pc};
      cur_cond = cond;
      #1;
      ldr  = in_e.ld && in_e.rw && (in_e.wa3 == ra1 || in_e.wa3 == ra2);
      pcp  = pc || in_e.pc || in_m.pc;
      e_sf = ldr || pcp;
      e_sd = ldr;
      e_fd = pcp || in_w.pc || br;
      e_fe = ldr || br;
      e_fa = fwd_of(in_e.ra1);
      e_fb = fwd_of(in_e.ra2);
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else begin
         if (e_sd) c_stall++;
         if (e_fd || e_fe) c_flush++;
         if (e_fa != 0 || e_fb != 0) c_fwd++;
         in_w = in_m;
         in_m = in_e;
         in_m.rw = in_e.rw && cur_cond;
         in_m.pc = in_e.pc && cur_cond;
         in_e = e_fe ? nop_ins() : cur_d;
      end
      #1;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 0);
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD,
           hz.FlushD, hz.FlushE} !== 8'h00) begin
         failures++;
         $display("FAIL reset_during got=%b exp=0",
            {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD,
             hz.FlushD, hz.FlushE});
      end
      tick();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD,
           hz.FlushD, hz.FlushE} !== 8'h00) begin
         failures++;
         $display("FAIL reset_after got=%b exp=0",
            {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD,
             hz.FlushD, hz.FlushE});
      end
      tick();
   endtask

   task automatic test_forward();
      nops(3);
      drive(0, 0, 1, 1, 0, 0, 1, 0); tick();
      drive(1, 3, 2, 1, 0, 0, 1, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (hz.ForwardAE !== 2'b10) begin
         failures++;
         $display("FAIL fwd_mem got=%b exp=10", hz.ForwardAE);
      end
      tick();
      nops(3);
      drive(0, 0, 1, 1, 0, 0, 1, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
      drive(6, 1, 2, 1, 0, 0, 1, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (hz.ForwardBE !== 2'b01 || hz.ForwardAE !== 2'b00) begin
         failures++;
         $display("FAIL fwd_wb got=%b%b exp=0001",
            hz.ForwardAE, hz.ForwardBE);
      end
      tick();
   endtask

   task automatic test_load_use();
      nops(3);
      drive(0, 0, 4, 1, 1, 0, 1, 0); tick();
      drive(4, 0, 5, 1, 0, 0, 1, 0);
      checks++;
      if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b111) begin
         failures++;
         $display("FAIL ldr_stall got=%b exp=111",
            {hz.StallF, hz.StallD, hz.FlushE});
      end
      tick();
      drive(4, 0, 5, 1, 0, 0, 1, 0);
      checks++;
      if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b000) begin
         failures++;
         $display("FAIL ldr_once got=%b exp=000",
            {hz.StallF, hz.StallD, hz.FlushE});
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (hz.ForwardAE !== 2'b01) begin
         failures++;
         $display("FAIL ldr_fwd got=%b exp=01", hz.ForwardAE);
      end
      tick();
   endtask

   task automatic test_pc_write();
      logic [4:0] exp_sf, exp_fd;
      exp_sf = 5'b11100;
      exp_fd = 5'b11110;
      nops(3);
      for (int i = 0; i < 5; i++) begin
         if (i == 0) drive(0, 0, 15, 1, 0, 1, 1, 0);
         else        drive(0, 0, 0, 0, 0, 0, 1, 0);
         checks++;
         if (hz.StallF !== exp_sf[4-i] || hz.FlushD !== exp_fd[4-i]) begin
            failures++;
            $display("FAIL pc_write cyc=%0d got=%b%b exp=%b%b", i,
               hz.StallF, hz.FlushD, exp_sf[4-i], exp_fd[4-i]);
         end
         tick();
      end
   endtask

   task automatic test_cond_fail();
      nops(3);
      drive(0, 0, 2, 1, 0, 0, 1, 0); tick();
      drive(2, 2, 7, 1, 0, 0, 0, 0); tick();
      drive(2, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (hz.ForwardAE !== 2'b00 || hz.ForwardBE !== 2'b00) begin
         failures++;
         $display("FAIL cond_fail got=%b%b exp=0000",
            hz.ForwardAE, hz.ForwardBE);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (hz.ForwardAE !== 2'b00) begin
         failures++;
         $display("FAIL cond_fail_w got=%b exp=00", hz.ForwardAE);
      end
      tick();
   endtask

   task automatic test_branch();
      nops(3);
      drive(0, 0, 1, 1, 0, 0, 1, 0); tick();
      drive(1, 1, 3, 1, 0, 0, 1, 1);
      checks++;
      if ({hz.FlushD, hz.FlushE} !== 2'b11) begin
         failures++;
         $display("FAIL branch_flush got=%b exp=11",
            {hz.FlushD, hz.FlushE});
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if ({hz.ForwardAE, hz.ForwardBE, hz.FlushD, hz.FlushE}
          !== 6'b0) begin
         failures++;
         $display("FAIL branch_bubble got=%b exp=000000",
            {hz.ForwardAE, hz.ForwardBE, hz.FlushD, hz.FlushE});
      end
      tick();
   endtask

   task automatic test_random();
      int r[3];
      bit ld, rw, pc, br, cond;
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < 3; k++) begin
            r[k] = $urandom_range(0, 6);
            if (r[k] == 6) r[k] = 15;
         end
         rw   = ($urandom_range(0, 3) != 0);
         ld   = ($urandom_range(0, 2) == 0);
         pc   = ($urandom_range(0, 9) == 0);
         br   = ($urandom_range(0, 9) == 0);
         cond = ($urandom_range(0, 4) != 0);
         drive(r[0], r[1], r[2], rw, ld, pc, cond, br);
         checks++;
         if (hz.ForwardAE !== e_fa[1:0] || hz.ForwardBE !== e_fb[1:0] ||
             hz.StallF !== e_sf || hz.StallD !== e_sd ||
             hz.FlushD !== e_fd || hz.FlushE !== e_fe) begin
            failures++;
            $display("FAIL rand n=%0d got=%b%b%b%b%b%b exp=%b%b%b%b%b%b",
               n, hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD,
               hz.FlushD, hz.FlushE, e_fa[1:0], e_fb[1:0],
               e_sf, e_sd, e_fd, e_fe);
         end
`ifdef HAZARD_STATS_EN
         checks++;
         if (hz.StallCnt !== c_stall[15:0] ||
             hz.FlushCnt !== c_flush[15:0] ||
             hz.FwdCnt !== c_fwd[15:0]) begin
            failures++;
            $display("FAIL rand_cnt n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
               n, hz.StallCnt, hz.FlushCnt, hz.FwdCnt,
               c_stall, c_flush, c_fwd);
         end
`endif
         tick();
      end
   endtask

   task automatic test_reset_midop();
      nops(3);
      drive(0, 0, 4, 1, 1, 0, 1, 0); tick();
      drive(0, 4, 5, 1, 0, 0, 1, 0);
      checks++;
      if (hz.StallD !== 1'b1) begin
         failures++;
         $display("FAIL midop_pre got=%b exp=1", hz.StallD);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD,
           hz.FlushD, hz.FlushE} !== 8'h00) begin
         failures++;
         $display("FAIL midop_reset got=%b exp=0",
            {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD,
             hz.FlushD, hz.FlushE});
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if (hz.StallCnt !== 16'd0 || hz.FlushCnt !== 16'd0 ||
          hz.FwdCnt !== 16'd0) begin
         failures++;
         $display("FAIL midop_cnt got=%0d/%0d/%0d exp=0/0/0",
            hz.StallCnt, hz.FlushCnt, hz.FwdCnt);
      end
`endif
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      drive(0, 4, 5, 1, 0, 0, 1, 0);
      checks++;
      if (hz.StallD !== 1'b0 || hz.ForwardAE !== 2'b00) begin
         failures++;
         $display("FAIL midop_after got=%b%b exp=000",
            hz.StallD, hz.ForwardAE);
      end
      tick();
   endtask

   initial begin
      reset = 1'b1;
      hz.RA1D = '0; hz.RA2D = '0; hz.WA3D = '0;
      hz.RegWriteD = 1'b0; hz.MemtoRegD = 1'b0; hz.PCSrcD = 1'b0;
      hz.CondExE = 1'b0; hz.BranchTakenE = 1'b0;
      model_reset();
      cur_d = nop_ins();
      cur_cond = 1'b0;
      test_reset();
      test_forward();
      test_load_use();
      test_pc_write();
      test_cond_fail();
      test_branch();
      test_random();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard resolver for the 5-stage ARM core. It sends stall, flush and forward controls back into the datapath and controller pipeline registers.
- Keeps its own shadow pipeline of destination-register and write-enable info for the E, M and W stages, so only Decode-stage fields and Execute-stage condition results are inputs.
- Resolves RAW hazards by forwarding, load-use hazards by a 1-cycle stall, and PC writes / taken branches by flushes.

Parameters:
- REG_AW, 4, register address width.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- RA1D  in  REG_AW  source register 1 of the Decode-stage instruction
- RA2D  in  REG_AW  source register 2 of the Decode-stage instruction
- WA3D  in  REG_AW  destination register of the Decode-stage instruction
- RegWriteD  in  1  Decode-stage instruction writes the register file
- MemtoRegD  in  1  Decode-stage instruction is a load
- PCSrcD  in  1  Decode-stage instruction writes R15
- CondExE  in  1  condition pass for the Execute-stage instruction
- BranchTakenE  in  1  branch resolved taken in Execute
- ForwardAE  out  2  SrcA select: 00 register file, 01 ResultW, 10 ALUResultM
- ForwardBE  out  2  SrcB select, same encoding as ForwardAE
- StallF  out  1  hold PC
- StallD  out  1  hold Fetch/Decode register
- FlushD  out  1  clear Fetch/Decode register
- FlushE  out  1  clear Decode/Execute register

Behaviour:
- Shadow pipeline, updated on rising clk:
  - E stage holds {RA1,RA2,WA3,RegWrite,MemtoReg,PCSrc}.
  - M stage holds {WA3,RegWrite,PCSrc}.
  - W stage holds {WA3,RegWrite,PCSrc}.
- Stage updates:
  - E <= D fields, or all-zero bubble when FlushE=1.
  - M <= E, with RegWriteM <= RegWriteE & CondExE and PCSrcM <= PCSrcE & CondExE.
  - W <= M.
  - StallD does not freeze E/M/W. The E bubble comes from FlushE, which is asserted together with StallD.
- Reset (asynchronous) clears all shadow stages to zero. With all inputs at zero, every output is 0 during and after reset.
- A reset asserted mid-operation discards all in-flight tracking immediately.
- Forwarding (combinational, per operand X in {A,B}, using RA1E/RA2E):
  - 10 if RegWriteM and WA3M == RAxE.
  - Else 01 if RegWriteW and WA3W == RAxE.
  - Else 00.
  - M has priority when M and W both match.
  - RAxE == 15 always yields 00 (PC reads are supplied by the datapath).
- Load-use:
  - ldrStall = MemtoRegE & RegWriteE & (WA3E == RA1D | WA3E == RA2D).
  - ldrStall lasts exactly 1 cycle, because the E bubble clears MemtoRegE.
- PC hazard: pcPend = PCSrcD | PCSrcE | PCSrcM.
- Output equations:
  - StallF = ldrStall | pcPend.
  - StallD = ldrStall.
  - FlushD = pcPend | PCSrcW | BranchTakenE.
  - FlushE = ldrStall | BranchTakenE.
- Simultaneous events:
  - BranchTakenE together with ldrStall: FlushE=1, StallD=1, FlushD=1. Flush dominates; the datapath treats FlushD as higher priority than StallD.
- Latency: all outputs are combinational from current inputs plus registered state. There is no output register.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds three CNT_W-bit outputs, each with an asynchronous reset to 0 and saturating at all-ones:
  - StallCnt increments each cycle StallD=1.
  - FlushCnt increments each cycle FlushE|FlushD=1.
  - FwdCnt increments each cycle ForwardAE!=0 or ForwardBE!=0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Forward encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Constant PC_REG=4'd15.
  - A stage-record typedef {wa3, regwrite, memtoreg, pcsrc}.
- One sub-module, hazard_track: the E/M/W shadow register chain with flush-to-bubble and CondExE gating. hazard_unit keeps the comparators and output logic.

Test Plan:
- ADD R1 then ADD R2,R1,R3 (RegWriteD=1, WA3D=1, then RA1D=1): next cycle ForwardAE=10. With one independent instruction in between, ForwardAE=01.
- LDR R4 then SUB R5,R4,#1: StallF=StallD=FlushE=1 for exactly 1 cycle. Two cycles later ForwardAE=01.
- MOV PC,R0 (PCSrcD=1, CondExE=1): StallF=1 for 3 consecutive cycles. FlushD=1 for 4 cycles (D,E,M,W). Returns to 0 afterwards.
- Conditional write failing (CondExE=0, WA3D=2, then RA1D=2): ForwardAE stays 00.
- BranchTakenE=1 for one cycle: FlushD=FlushE=1 in that same cycle. Following cycle, E holds a bubble and no forwarding occurs.
- Assert reset while a load-use stall is pending: all outputs drop to 0 asynchronously. With HAZARD_STATS_EN, counters read 0 after reset.
